// File: rtl/riskproc_pkg.sv
// Shared integer-pipeline definitions: RV32 opcode constants and the ALU control bundle
// carried by each reservation-station entry.
package riskproc_pkg;

  localparam logic [6:0] R_type    = 7'b0110011;
  localparam logic [6:0] I_type_1  = 7'b0000011;
  localparam logic [6:0] I_type_2  = 7'b0010011;
  localparam logic [6:0] I_jalr    = 7'b1100111;
  localparam logic [6:0] S_type    = 7'b0100011;
  localparam logic [6:0] B_type    = 7'b1100011;
  localparam logic [6:0] U_type    = 7'b0110111;
  localparam logic [6:0] U_type_pc = 7'b0010111;
  localparam logic [6:0] J_type    = 7'b1101111;

  typedef struct packed {
    logic [6:0] opcode;
    logic [5:0] funct3;
    logic [6:0] funct7;
    logic [6:0] imm_funct;
    logic [4:0] reduced_imm;
  } alu_ctl_t;

endpackage

// File: rtl/alu_rs_select.sv
// Oldest-eligible picker: a larger age means dispatched earlier. Ages of valid
// entries are unique, so the grant is one-hot.
module alu_rs_select #(
  parameter int RS_DEPTH = 4,
  parameter int AGE_W    = 2
) (
  input  logic [RS_DEPTH-1:0]            elig_i,
  input  logic [RS_DEPTH-1:0][AGE_W-1:0] age_i,
  output logic [RS_DEPTH-1:0]            grant_o,
  output logic                           found_o
);

  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      grant_o[i] = elig_i[i];
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (j != i && elig_i[j] && (age_i[j] > age_i[i])) grant_o[i] = 1'b0;
      end
    end
    found_o = |elig_i;
  end

endmodule

// File: rtl/alu_reservation_station.sv
// Integer ALU reservation station: buffers dispatched ops, wakes sources from the result
// broadcast and issues the oldest ready op. Define RS_CDB_WAKEUP_SELECT_EN to select on wakeup.
module alu_reservation_station
  import riskproc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int RS_DEPTH   = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      disp_valid,
  output logic                      disp_ready,
  input  logic [6:0]                disp_opcode,
  input  logic [5:0]                disp_funct3,
  input  logic [6:0]                disp_funct7,
  input  logic [6:0]                disp_imm_funct,
  input  logic [4:0]                disp_reduced_imm,
  input  logic [ID_WIDTH-1:0]       disp_dest_tag,
  input  logic                      disp_src1_rdy,
  input  logic [ID_WIDTH-1:0]       disp_src1_tag,
  input  logic [DATA_WIDTH-1:0]     disp_src1_val,
  input  logic                      disp_src2_rdy,
  input  logic [ID_WIDTH-1:0]       disp_src2_tag,
  input  logic [DATA_WIDTH-1:0]     disp_src2_val,
  input  logic                      cdb_valid,
  input  logic [ID_WIDTH-1:0]       cdb_tag,
  input  logic [DATA_WIDTH-1:0]     cdb_data,
  input  logic                      issue_stall,
  output logic [6:0]                opcode,
  output logic [5:0]                funct3,
  output logic [6:0]                funct7,
  output logic [6:0]                Imm_funct,
  output logic [4:0]                reduced_Imm,
  output logic [DATA_WIDTH-1:0]     BusWires1,
  output logic [DATA_WIDTH-1:0]     BusWires2,
  output logic [ID_WIDTH-1:0]       tag,
  output logic                      data_out_valid,
  output logic [$clog2(RS_DEPTH):0] occupancy
);

  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int CNT_W = IDX_W + 1;

  // age = number of currently valid entries dispatched after this one
  typedef struct packed {
    logic                  valid;
    logic [IDX_W-1:0]      age;
    alu_ctl_t              ctl;
    logic [ID_WIDTH-1:0]   dest_tag;
    logic                  s1_rdy;
    logic [ID_WIDTH-1:0]   s1_tag;
    logic [DATA_WIDTH-1:0] s1_val;
    logic                  s2_rdy;
    logic [ID_WIDTH-1:0]   s2_tag;
    logic [DATA_WIDTH-1:0] s2_val;
  } rs_entry_t;

  rs_entry_t ent_q [RS_DEPTH];
  rs_entry_t ent_d [RS_DEPTH];

  logic [CNT_W-1:0]                occ_q, occ_d;
  logic [RS_DEPTH-1:0]             s1_hit, s2_hit, elig, grant, free_oh;
  logic [RS_DEPTH-1:0][IDX_W-1:0]  age_vec;
  logic                            found, do_issue, disp_fire;
  logic                            d_s1_hit, d_s2_hit;
  logic [IDX_W-1:0]                iss_age;
  alu_ctl_t                        disp_ctl, iss_ctl, out_ctl_q;
  logic [ID_WIDTH-1:0]             iss_tag, out_tag_q;
  logic [DATA_WIDTH-1:0]           iss_a, iss_b, out_a_q, out_b_q;
  logic                            out_vld_q;

  assign disp_ready = (occ_q < CNT_W'(RS_DEPTH));
  assign disp_fire  = disp_valid && disp_ready;
  assign do_issue   = found && !issue_stall;

  assign disp_ctl = '{opcode: disp_opcode, funct3: disp_funct3, funct7: disp_funct7,
                      imm_funct: disp_imm_funct, reduced_imm: disp_reduced_imm};

  assign d_s1_hit = cdb_valid && !disp_src1_rdy && (disp_src1_tag == cdb_tag);
  assign d_s2_hit = cdb_valid && !disp_src2_rdy && (disp_src2_tag == cdb_tag);

  always_comb begin : wake_elig
    s1_hit  = '0;
    s2_hit  = '0;
    elig    = '0;
    age_vec = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      s1_hit[i] = ent_q[i].valid && !ent_q[i].s1_rdy && cdb_valid && (ent_q[i].s1_tag == cdb_tag);
      s2_hit[i] = ent_q[i].valid && !ent_q[i].s2_rdy && cdb_valid && (ent_q[i].s2_tag == cdb_tag);
`ifdef RS_CDB_WAKEUP_SELECT_EN
      elig[i] = ent_q[i].valid && (ent_q[i].s1_rdy || s1_hit[i]) && (ent_q[i].s2_rdy || s2_hit[i]);
`else
      elig[i] = ent_q[i].valid && ent_q[i].s1_rdy && ent_q[i].s2_rdy;
`endif
      age_vec[i] = ent_q[i].age;
    end
  end

  alu_rs_select #(
    .RS_DEPTH (RS_DEPTH),
    .AGE_W    (IDX_W)
  ) u_sel (
    .elig_i  (elig),
    .age_i   (age_vec),
    .grant_o (grant),
    .found_o (found)
  );

  // lowest-index free slot; disp_ready guarantees one exists when dispatch fires
  always_comb begin : free_pick
    free_oh = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!ent_q[i].valid) begin
        free_oh    = '0;
        free_oh[i] = 1'b1;
      end
    end
  end

  // a not-yet-ready source can only be granted via the same-cycle broadcast
  always_comb begin : iss_mux
    iss_age = '0;
    iss_ctl = '0;
    iss_tag = '0;
    iss_a   = '0;
    iss_b   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grant[i]) begin
        iss_age = ent_q[i].age;
        iss_ctl = ent_q[i].ctl;
        iss_tag = ent_q[i].dest_tag;
        iss_a   = ent_q[i].s1_rdy ? ent_q[i].s1_val : cdb_data;
        iss_b   = ent_q[i].s2_rdy ? ent_q[i].s2_val : cdb_data;
      end
    end
  end

  always_comb begin : nxt
    occ_d = occ_q + CNT_W'(disp_fire) - CNT_W'(do_issue);
    for (int i = 0; i < RS_DEPTH; i++) begin
      ent_d[i] = ent_q[i];
      if (s1_hit[i]) begin
        ent_d[i].s1_rdy = 1'b1;
        ent_d[i].s1_val = cdb_data;
      end
      if (s2_hit[i]) begin
        ent_d[i].s2_rdy = 1'b1;
        ent_d[i].s2_val = cdb_data;
      end
      // keep ages dense so they never exceed RS_DEPTH-1 across issue holes
      if (ent_q[i].valid && do_issue && (ent_q[i].age > iss_age))
        ent_d[i].age = ent_d[i].age - IDX_W'(1);
      if (ent_q[i].valid && disp_fire)
        ent_d[i].age = ent_d[i].age + IDX_W'(1);
      if (do_issue && grant[i])
        ent_d[i].valid = 1'b0;
      if (disp_fire && free_oh[i]) begin
        ent_d[i].valid    = 1'b1;
        ent_d[i].age      = '0;
        ent_d[i].ctl      = disp_ctl;
        ent_d[i].dest_tag = disp_dest_tag;
        ent_d[i].s1_rdy   = disp_src1_rdy || d_s1_hit;
        ent_d[i].s1_tag   = disp_src1_tag;
        ent_d[i].s1_val   = d_s1_hit ? cdb_data : disp_src1_val;
        ent_d[i].s2_rdy   = disp_src2_rdy || d_s2_hit;
        ent_d[i].s2_tag   = disp_src2_tag;
        ent_d[i].s2_val   = d_s2_hit ? cdb_data : disp_src2_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= '0;
      occ_q     <= '0;
      out_vld_q <= 1'b0;
      out_ctl_q <= '0;
      out_tag_q <= '0;
      out_a_q   <= '0;
      out_b_q   <= '0;
    end else begin
      for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
      occ_q     <= occ_d;
      out_vld_q <= do_issue;
      if (do_issue) begin
        out_ctl_q <= iss_ctl;
        out_tag_q <= iss_tag;
        out_a_q   <= iss_a;
        out_b_q   <= iss_b;
      end
    end
  end

  assign data_out_valid = out_vld_q;
  assign opcode         = out_ctl_q.opcode;
  assign funct3         = out_ctl_q.funct3;
  assign funct7         = out_ctl_q.funct7;
  assign Imm_funct      = out_ctl_q.imm_funct;
  assign reduced_Imm    = out_ctl_q.reduced_imm;
  assign BusWires1      = out_a_q;
  assign BusWires2      = out_b_q;
  assign tag            = out_tag_q;
  assign occupancy      = occ_q;

endmodule
